wptr_sync_lvl: RTL
==================

WPTR_SYNC_LVL -- requirements
Module: wptr_sync_lvl

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4, FIFO address bits; pointers are ADDRSIZE+1 bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth; legal range 2..4.
REQ-003 SHALL have parameter AE_THRESH, default 2, almost-empty threshold in entries; legal range 1..2^ADDRSIZE.
REQ-004 SHALL have port rclk  input  1  read-domain clock.
REQ-005 SHALL have port rrst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wptr  input  ADDRSIZE+1  Gray write pointer from the write domain.
REQ-007 SHALL have port rptr  input  ADDRSIZE+1  Gray read pointer, already in the rclk domain.
REQ-008 SHALL have port err_clr  input  1  clears the sticky error flags.
REQ-009 SHALL have port rq_wptr  output  ADDRSIZE+1  synchronized Gray write pointer.
REQ-010 SHALL have port rq_wbin  output  ADDRSIZE+1  binary form of rq_wptr.
REQ-011 SHALL have port rlevel  output  ADDRSIZE+1  fill level in entries.
REQ-012 SHALL have port rempty_lvl  output  1  rlevel == 0.
REQ-013 SHALL have port ralmost_empty  output  1  rlevel <= AE_THRESH.
REQ-014 SHALL have port rgray_err  output  1  sticky flag: more than one Gray bit changed between samples.
REQ-015 SHALL have port rovf_err  output  1  sticky flag: level exceeds 2^ADDRSIZE.

Function
REQ-016 SHALL sample wptr through a SYNC_STAGES-deep flop chain on rclk; rq_wptr is the last stage, so latency is exactly SYNC_STAGES rclk edges.
REQ-017 SHALL register rq_wbin <= gray2bin(rq_wptr), and rbin_q <= gray2bin(rptr) internally, on the same edge (pipeline stage P1).
REQ-018 SHALL register rlevel <= (rq_wbin - rbin_q) mod 2^(ADDRSIZE+1) in stage P2; wptr-to-rlevel latency is SYNC_STAGES+2 edges, and rptr-to-rlevel latency is 2 edges.
REQ-019 SHALL register rempty_lvl and ralmost_empty in P2 from the same difference as rlevel, so all three are cycle-coherent.
REQ-020 SHALL set rgray_err when the popcount of (new rq_wptr XOR previous rq_wptr) > 1, one edge after the offending rq_wptr value appears.
REQ-021 SHALL set rovf_err in P2 when the difference > 2^ADDRSIZE.
REQ-022 SHALL hold rgray_err and rovf_err until err_clr is sampled high; set and err_clr in the same cycle leave the flag set.
REQ-023 SHALL handle pointer wrap-around through modular subtraction: wbin=1, rbin=31 (ADDRSIZE=4) gives rlevel=2.
REQ-024 SHALL treat rlevel == 2^ADDRSIZE (full) as legal, with no rovf_err.
REQ-025 SHALL have no combinational path from any input to any output.

Reset
REQ-026 SHALL, while rrst_n is low, asynchronously clear all sync stages, rq_wptr, rq_wbin, rbin_q, rlevel, rgray_err and rovf_err to 0.
REQ-027 SHALL drive rempty_lvl=1 and ralmost_empty=1 during reset.
REQ-028 SHALL NOT flag rgray_err on the first post-reset sample; the previous-value register resets to 0, matching the reset pointers.
REQ-029 SHALL, when reset is asserted mid-operation, return every output to its reset value immediately, with no dependence on rclk.

Structure
REQ-030 SHALL place the gray2bin and popcount functions and the SYNC_STAGES legality check in the shared package fifo_sync_pkg.
REQ-031 SHALL implement the flop chain as sub-module sync_chain (params WIDTH, STAGES; ports clk, rst_n, d, q), reusable by the read-to-write-side counterpart.

Verification
REQ-032 SHALL cover: SYNC_STAGES=3, wptr Gray 0->1 at edge N -> rq_wptr=1 at edge N+3, rq_wbin=1 at N+4, rlevel=1 at N+5.
REQ-033 SHALL cover: ADDRSIZE=4, rptr=gray(31), wptr stepped Gray-wise to gray(1) -> rlevel=2, rempty_lvl=0, ralmost_empty=1.
REQ-034 SHALL cover: wptr jumps 00000->00011 -> rgray_err=1 and held; err_clr pulse -> 0 on the next edge; set plus err_clr in the same cycle -> stays 1.
REQ-035 SHALL cover: wbin=17, rbin=0 -> rovf_err=1; wbin=16, rbin=0 -> rlevel=16, rovf_err=0.
REQ-036 SHALL cover: rrst_n low mid-stream at rlevel=5 -> all outputs at reset values before the next rclk edge, with rempty_lvl=1.
REQ-037 SHALL cover: AE_THRESH=2, level sweep 0..4 -> ralmost_empty=1,1,1,0,0.

Source files
------------

// File: rtl/fifo_sync_pkg.sv
// ---------------------------------------------------------------------------
// fifo_sync_pkg
// Helpers shared by the clock-domain-crossing pointer synchronizers of the
// async FIFO: Gray-to-binary conversion, population count, the synchronizer
// depth legality check and the sticky error flag bundle.
//
// The functions work on a fixed maximum width (PTR_MAX_W). Callers zero-extend
// narrower pointers in and truncate results back out. Zero-extending a Gray
// code does not change its binary value, so this is exact.
// ---------------------------------------------------------------------------
package fifo_sync_pkg;

  localparam int PTR_MAX_W = 17;
  localparam int SYNC_MIN  = 2;
  localparam int SYNC_MAX  = 4;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  // Sticky error flags raised on the read side of the crossing.
  typedef struct packed {
    logic gray;  // more than one Gray bit moved between two samples
    logic ovf;   // fill level above the FIFO depth
  } err_flags_t;

  // Binary bit i is the XOR of all Gray bits from the MSB down to i.
  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input ptr_max_t v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < PTR_MAX_W; i++) begin
      cnt += int'(v[i]);
    end
    return cnt;
  endfunction

  function automatic bit sync_stages_ok(input int stages);
    return (stages >= SYNC_MIN) && (stages <= SYNC_MAX);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
// Multi-flop synchronizer for a bus that changes at most one bit per update
// (a Gray pointer). It is used by both the write-to-read and the
// read-to-write pointer crossings.
//
// Parameters:
//   WIDTH  - bus width
//   STAGES - number of flops; q is the last flop, so latency is STAGES edges
// Ports:
//   clk    in   destination-domain clock
//   rst_n  in   asynchronous active-low reset; clears every stage
//   d      in   WIDTH  bus from the source domain
//   q      out  WIDTH  synchronized bus
// ---------------------------------------------------------------------------
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/wptr_sync_lvl.sv
// ---------------------------------------------------------------------------
// wptr_sync_lvl
// This block brings the FIFO Gray write pointer into the read clock domain.
// It derives the fill level and the flags that depend on the level, and it
// watches the crossing for two faults.
//
// Pipeline (all on rclk):
//   sync : wptr -> SYNC_STAGES flops -> rq_wptr
//   P1   : rq_wbin <= bin(rq_wptr), rbin_q <= bin(rptr)
//   P2   : rlevel, rempty_lvl, ralmost_empty, rovf_err from one difference
// Every output comes straight from a flop. No input has a combinational
// path to any output.
//
// Parameters:
//   ADDRSIZE    - FIFO address bits; pointers are ADDRSIZE+1 bits
//   SYNC_STAGES - synchronizer depth, 2..4
//   AE_THRESH   - almost-empty threshold in entries, 1..2^ADDRSIZE
// Ports:
//   rclk          in   read-domain clock
//   rrst_n        in   asynchronous active-low reset
//   wptr          in   Gray write pointer (write domain)
//   rptr          in   Gray read pointer (already rclk domain)
//   err_clr       in   clears the sticky error flags
//   rq_wptr       out  synchronized Gray write pointer
//   rq_wbin       out  binary form of rq_wptr (one edge later)
//   rlevel        out  fill level in entries
//   rempty_lvl    out  rlevel == 0
//   ralmost_empty out  rlevel <= AE_THRESH
//   rgray_err     out  sticky: multi-bit Gray change seen on rq_wptr
//   rovf_err      out  sticky: level above 2^ADDRSIZE
// ---------------------------------------------------------------------------
module wptr_sync_lvl
  import fifo_sync_pkg::*;
#(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic [ADDRSIZE:0] wptr,
  input  logic [ADDRSIZE:0] rptr,
  input  logic              err_clr,
  output logic [ADDRSIZE:0] rq_wptr,
  output logic [ADDRSIZE:0] rq_wbin,
  output logic [ADDRSIZE:0] rlevel,
  output logic              rempty_lvl,
  output logic              ralmost_empty,
  output logic              rgray_err,
  output logic              rovf_err
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] FULL_LVL = {1'b1, {ADDRSIZE{1'b0}}};
  localparam logic [PW-1:0] AE_LVL   = PW'(AE_THRESH);

  // Bad parameters stop elaboration.
  if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
    $error("wptr_sync_lvl: SYNC_STAGES must be in 2..4");
  end
  if (PW > PTR_MAX_W) begin : g_bad_addrsize
    $error("wptr_sync_lvl: ADDRSIZE too large for fifo_sync_pkg helpers");
  end
  if ((AE_THRESH < 1) || (AE_THRESH > (1 << ADDRSIZE))) begin : g_bad_ae
    $error("wptr_sync_lvl: AE_THRESH must be in 1..2^ADDRSIZE");
  end

  // ---------------- synchronizer ----------------
  logic [PW-1:0] sync_q;

  sync_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (rclk),
    .rst_n (rrst_n),
    .d     (wptr),
    .q     (sync_q)
  );

  // ---------------- registers ----------------
  logic [PW-1:0] wprev_q;              // rq_wptr from the previous edge
  logic [PW-1:0] rq_wbin_q, rq_wbin_d;
  logic [PW-1:0] rbin_q,    rbin_d;
  logic [PW-1:0] rlevel_q,  rlevel_d;
  logic          rempty_q,  rempty_d;
  logic          rae_q,     rae_d;
  err_flags_t    err_q,     err_d;

  // ---------------- next state ----------------
  logic [PW-1:0] diff;
  logic          gray_bad;
  logic          lvl_ovf;

  always_comb begin
    rq_wbin_d = PW'(gray2bin(PTR_MAX_W'(sync_q)));
    rbin_d    = PW'(gray2bin(PTR_MAX_W'(rptr)));

    // Modular subtraction handles pointer wrap-around for free.
    diff      = rq_wbin_q - rbin_q;
    rlevel_d  = diff;
    rempty_d  = (diff == '0);
    rae_d     = (diff <= AE_LVL);
    lvl_ovf   = (diff > FULL_LVL);

    // Both values reset to 0, so the first sample after reset never trips.
    gray_bad  = popcount(PTR_MAX_W'(sync_q ^ wprev_q)) > 1;

    // Setting has priority over err_clr, so an error seen in the same
    // cycle as a clear is not lost.
    err_d = err_q;
    if (gray_bad) begin
      err_d.gray = 1'b1;
    end else if (err_clr) begin
      err_d.gray = 1'b0;
    end
    if (lvl_ovf) begin
      err_d.ovf = 1'b1;
    end else if (err_clr) begin
      err_d.ovf = 1'b0;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      wprev_q   <= '0;
      rq_wbin_q <= '0;
      rbin_q    <= '0;
      rlevel_q  <= '0;
      rempty_q  <= 1'b1;
      rae_q     <= 1'b1;
      err_q     <= '0;
    end else begin
      wprev_q   <= sync_q;
      rq_wbin_q <= rq_wbin_d;
      rbin_q    <= rbin_d;
      rlevel_q  <= rlevel_d;
      rempty_q  <= rempty_d;
      rae_q     <= rae_d;
      err_q     <= err_d;
    end
  end

  // ---------------- outputs ----------------
  assign rq_wptr       = sync_q;
  assign rq_wbin       = rq_wbin_q;
  assign rlevel        = rlevel_q;
  assign rempty_lvl    = rempty_q;
  assign ralmost_empty = rae_q;
  assign rgray_err     = err_q.gray;
  assign rovf_err      = err_q.ovf;

endmodule
